// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: accepts an N-bit word and shifts it out
// MSB-first on sout, holding each bit for DIV clock cycles.
module piso_serializer #(
  parameter int N   = 4,
  parameter int DIV = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [N-1:0] din,
  output logic         sout,
  output logic         sout_valid,
  output logic         busy,
  output logic         done,
  output logic [1:0]   state_dbg
);

  localparam int BW = $clog2(N) + 1;
  localparam int DW = $clog2(DIV) + 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [N-1:0]  shreg, shreg_nx;
  logic [BW-1:0] bit_cnt, bit_cnt_nx;
  logic [DW-1:0] div_cnt, div_cnt_nx;

  // Handshake: a word transfers on any rising edge where load_valid and
  // load_ready are both high; load_valid seen while not ready is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else begin
      state   <= state_nx;
      shreg   <= shreg_nx;
      bit_cnt <= bit_cnt_nx;
      div_cnt <= div_cnt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    shreg_nx   = shreg;
    bit_cnt_nx = bit_cnt;
    div_cnt_nx = div_cnt;
    case (state)
      IDLE: begin
        if (load_valid) begin
          shreg_nx   = din;
          bit_cnt_nx = '0;
          div_cnt_nx = '0;
          state_nx   = SHIFT;
        end
      end
      SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_nx = '0;
          // Left shift also covers N=1, where the register simply clears.
          shreg_nx   = shreg << 1;
          if (bit_cnt == BIT_LAST) state_nx = DONE;
          else bit_cnt_nx = bit_cnt + 1'b1;
        end else begin
          div_cnt_nx = div_cnt + 1'b1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Every output is forced low while reset is held, even mid-frame.
  assign load_ready = (state == IDLE) && !rst;
  assign sout       = (state == SHIFT) && !rst && shreg[N-1];
  assign sout_valid = (state == SHIFT) && !rst;
  assign busy       = (state != IDLE) && !rst;
  assign done       = (state == DONE) && !rst;
  assign state_dbg  = state;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three configurations (4/1, 4/3, 1/1) run in
// parallel against a frame-timeline model and a loopback scoreboard.
module tb_piso_serializer;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   fin [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int NN = (g == 2) ? 1 : 4;
    localparam int DD = (g == 1) ? 3 : 1;

    logic          rst, load_valid, load_ready, sout, sout_valid, busy, done;
    logic [NN-1:0] din;
    logic [1:0]    state_dbg;

    logic [NN-1:0] exp_q[$];
    bit            active = 1'b0;
    int            acc_t = 0;
    int            acc_cnt = 0;
    logic [NN-1:0] word = '0;

    piso_serializer #(.N(NN), .DIV(DD)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .din        (din),
      .sout       (sout),
      .sout_valid (sout_valid),
      .busy       (busy),
      .done       (done),
      .state_dbg  (state_dbg)
    );

    // Timeline model: a frame accepted at the end of cycle T drives bit k in
    // cycles T+1+k*DD .. T+(k+1)*DD, done in T+NN*DD+1, ready again after.
    always @(negedge clk) begin
      int p;
      logic [4:0] e, a;
      p = cyc - acc_t;
      e = '0;
      if (rst)                 e = 5'b00000;
      else if (!active)        e = 5'b10000;
      else if (p <= NN * DD)   e = {1'b0, word[NN-1-(p-1)/DD], 3'b110};
      else                     e = 5'b00011;
      a = {load_ready, sout, sout_valid, busy, done};
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL outputs[%0d] cyc %0d {rdy,sout,vld,busy,done}: got %b want %b",
                 g, cyc, a, e);
      end
      if (rst) begin
        if (active) void'(exp_q.pop_back());
        active = 1'b0;
      end else if (!active) begin
        if (load_valid) begin
          active = 1'b1;
          acc_t  = cyc;
          word   = din;
          exp_q.push_back(din);
          acc_cnt++;
        end
      end else if (p == NN * DD + 1) begin
        active = 1'b0;
      end
    end

    // Loopback receiver: rebuilds each word from sout and checks it at done.
    logic [NN-1:0] rx = '0;
    int            rx_n = 0;
    always @(negedge clk) begin
      logic [NN-1:0] w;
      if (rst) begin
        rx   = '0;
        rx_n = 0;
      end else begin
        if (sout_valid) begin
          if (rx_n % DD == 0) rx = (rx << 1) | NN'(sout);
          rx_n++;
        end
        if (done) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL frame[%0d] cyc %0d: done with no word outstanding", g, cyc);
          end else begin
            w = exp_q.pop_front();
            if (rx !== w || rx_n != NN * DD) begin
              n_err++;
              $display("FAIL frame[%0d] cyc %0d: got %b (%0d valid cycles) want %b (%0d)",
                       g, cyc, rx, rx_n, w, NN * DD);
            end
          end
          rx   = '0;
          rx_n = 0;
        end
      end
    end

    task automatic send(input logic [NN-1:0] w, input bit keep);
      int start, k;
      start      = acc_cnt;
      load_valid = 1'b1;
      din        = w;
      k          = 0;
      while (acc_cnt == start && k < 100) begin
        @(posedge clk); #1;
        k++;
      end
      n_cmp++;
      if (acc_cnt == start) begin
        n_err++;
        $display("FAIL accept_timeout[%0d]: accepts %0d want %0d", g, acc_cnt, start + 1);
      end
      if (!keep) load_valid = 1'b0;
    endtask

    initial begin
      int k;
      rst        = 1'b1;
      load_valid = 1'b0;
      din        = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      // basic frame, then loopback words
      send(NN'(4'b1101), 1'b0);
      send(NN'(4'b1011), 1'b0);
      send(NN'(4'b0000), 1'b0);
      send(NN'(4'b1111), 1'b0);
      send(NN'(4'b1001), 1'b0);
      // back-to-back with din changing during the first frame
      send(NN'(4'b0110), 1'b1);
      send(NN'(4'b1001), 1'b0);
      // reset during bit 1
      send(NN'(4'b1111), 1'b0);
      repeat (DD) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      send(NN'(4'b0101), 1'b0);
      // randomized traffic
      repeat (30) begin
        repeat ($urandom_range(0, 3)) begin
          din = NN'($urandom);
          @(posedge clk); #1;
        end
        send(NN'($urandom), ($urandom_range(0, 3) == 0));
      end
      load_valid = 1'b0;
      k = 0;
      while (active && k < 200) begin
        @(posedge clk); #1;
        k++;
      end
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (exp_q.size() != 0 || active) begin
        n_err++;
        $display("FAIL drain[%0d]: %0d words outstanding, active=%0d want 0", g,
                 exp_q.size(), active);
      end
      fin[g] = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(fin[0] && fin[1] && fin[2]) && t < 50000) begin
      @(posedge clk);
      t++;
    end
    #2;
    if (!(fin[0] && fin[1] && fin[2])) begin
      n_cmp++;
      n_err++;
      $display("FAIL run_timeout: finished %0d%0d%0d want 111", fin[0], fin[1], fin[2]);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter: the sending end of the team's serial-in shift-register link.
- Accepts an N-bit word through a valid/ready handshake.
- Shifts the word out MSB-first on `sout`, one bit per DIV clock cycles, with a framing strobe and an end-of-frame pulse.
- Feeds digit/segment data to serial-loaded display and shift-register stages in the digital clock.

Parameters:
- N, 4, word width in bits (N >= 1).
- DIV, 1, clock cycles each bit is held on `sout` (DIV >= 1).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- load_valid  input  1  producer has a word on `din`.
- load_ready  output  1  serializer can accept a word.
- din  input  N  parallel word; sampled only on the accept cycle.
- sout  output  1  serial data, MSB first.
- sout_valid  output  1  high while `sout` carries a frame bit.
- busy  output  1  high from the cycle after accept through the DONE cycle.
- done  output  1  one-cycle pulse after the last bit.

Behaviour:
- Registers:
  - state: IDLE / SHIFT / DONE.
  - shreg[N-1:0].
  - bit_cnt, width clog2(N)+1.
  - div_cnt, width clog2(DIV)+1.
- Reset (rst=1 at a clk edge):
  - state=IDLE, shreg=0, counters=0.
  - While rst is high: sout=0, sout_valid=0, busy=0, done=0, load_ready=0.
- Output decode:
  - load_ready = (state==IDLE) && !rst.
  - sout = shreg[N-1] when state==SHIFT, else 0.
  - sout_valid = (state==SHIFT).
  - busy = (state!=IDLE).
  - done = (state==DONE).
- Accept:
  - Occurs when load_valid && load_ready at an edge (cycle T).
  - Loads shreg<=din, bit_cnt<=0, div_cnt<=0, state<=SHIFT.
- SHIFT, each edge:
  - If div_cnt==DIV-1:
    - div_cnt<=0.
    - shreg<={shreg[N-2:0],1'b0}; for N=1, shreg<=0.
    - If bit_cnt==N-1, state<=DONE; else bit_cnt<=bit_cnt+1.
  - Otherwise div_cnt<=div_cnt+1.
- DONE: lasts exactly one cycle, then state<=IDLE.
- Timing:
  - Bit k (k=0 is the MSB) is valid during cycles T+1+k*DIV through T+(k+1)*DIV.
  - done is high in cycle T+N*DIV+1.
  - load_ready returns in cycle T+N*DIV+2.
- Back-to-back frames:
  - The next accept can occur at the first edge in IDLE.
  - The minimum gap between frames is exactly 2 cycles with sout_valid=0 (the DONE cycle plus the accept cycle).
- load_valid outside IDLE:
  - Ignored; no capture, no stall of the current frame.
  - If it is still held when IDLE is reached, the word is accepted then.
- din is don't-care except in the accept cycle; changes during SHIFT must not affect `sout`.
- Reset mid-frame:
  - Aborts at the next edge: IDLE, sout_valid=0, sout=0.
  - No done pulse; the partial frame is discarded.
- No over-/under-flow: the single word buffer is only written in IDLE.

Test Plan:
- Basic frame (N=4, DIV=1):
  - Stimulus: reset 2 cycles, then load 4'b1101 at T.
  - Required: sout=1,1,0,1 in cycles T+1..T+4 with sout_valid=1; done=1 in T+5 only; load_ready=1 again in T+6; busy high T+1..T+5.
- Loopback:
  - Stimulus: drive `sout` into a serial-in left-shift register, enabled by sout_valid; send 4'b1011.
  - Required: the receiver's parallel output equals 4'b1011 after the done pulse; repeat for 4'b0000 and 4'b1111.
- Divider (N=4, DIV=3):
  - Stimulus: load 4'b1001 at T.
  - Required: each bit held exactly 3 cycles (1 during T+1..T+3, 0 during T+4..T+9, 1 during T+10..T+12); done in T+13.
- Busy/back-to-back:
  - Stimulus: hold load_valid=1, with din=4'b0110 at the first accept, then change din to 4'b1001 during SHIFT.
  - Required: first frame shifts 0,1,1,0 unaffected by the change; second accept occurs in the first IDLE cycle and shifts 1,0,0,1; exactly 2 idle cycles between frames.
- Reset mid-frame:
  - Stimulus: load 4'b1111, assert rst for 1 cycle after bit 1.
  - Required: sout=0 and sout_valid=0 from the following cycle; no done pulse; load_ready=1 the cycle after rst drops; a new word 4'b0101 then transmits correctly.
- Edge width (N=1, DIV=1):
  - Stimulus: load 1'b1.
  - Required: sout=1 for one cycle, done the next cycle, load_ready the cycle after that.
